// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU.
// Produces {remainder, quotient} after 32 single-bit steps.
`timescale 1ns/1ps
module div_unit (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        cancel,
   input  logic        signed_div,
   input  logic [31:0] opdata_a,
   input  logic [31:0] opdata_b,
   output logic        busy,
   output logic        done,
   output logic [63:0] result
);

   typedef enum logic [1:0] {IDLE, ZERO, RUN, FINISH} state_t;

   state_t      state_reg, state_next;
   logic [4:0]  count_reg;
   logic [31:0] rem_reg;
   logic [31:0] quo_reg;
   logic [31:0] dsr_reg;
   logic        neg_q_reg;
   logic        neg_r_reg;
   logic [63:0] result_reg;

   logic        accept;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [32:0] rem_shift;
   logic [32:0] diff;
   logic        take;
   logic [31:0] rem_step;
   logic [31:0] quo_step;
   logic [31:0] q_fix;
   logic [31:0] r_fix;

   assign accept = start && !cancel;

   // Signed mode works on magnitudes; 0x80000000 maps to itself as unsigned.
   assign abs_a = (signed_div && opdata_a[31]) ? (32'd0 - opdata_a) : opdata_a;
   assign abs_b = (signed_div && opdata_b[31]) ? (32'd0 - opdata_b) : opdata_b;

   // quo_reg holds the not-yet-consumed dividend bits and collects quotient bits from the right.
   assign rem_shift = {rem_reg, quo_reg[31]};
   assign diff      = rem_shift - {1'b0, dsr_reg};
   assign take      = !diff[32];
   assign rem_step  = take ? diff[31:0] : rem_shift[31:0];
   assign quo_step  = {quo_reg[30:0], take};

   assign q_fix = neg_q_reg ? (32'd0 - quo_step) : quo_step;
   assign r_fix = neg_r_reg ? (32'd0 - rem_step) : rem_step;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = (opdata_b == 32'd0) ? ZERO : RUN;
            end
         end
         ZERO:   state_next = IDLE;
         RUN: begin
            if (cancel) begin
               state_next = IDLE;
            end else if (count_reg == 5'd31) begin
               state_next = FINISH;
            end
         end
         FINISH: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_reg != IDLE);
      done = (state_reg == ZERO) || (state_reg == FINISH);
   end

   assign result = result_reg;

   // The result register is written on the edge entering ZERO/FINISH so it is valid alongside done.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_reg  <= 5'd0;
         rem_reg    <= 32'd0;
         quo_reg    <= 32'd0;
         dsr_reg    <= 32'd0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         result_reg <= 64'd0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  count_reg <= 5'd0;
                  rem_reg   <= 32'd0;
                  quo_reg   <= abs_a;
                  dsr_reg   <= abs_b;
                  neg_q_reg <= signed_div && (opdata_a[31] ^ opdata_b[31]);
                  neg_r_reg <= signed_div && opdata_a[31];
                  if (opdata_b == 32'd0) begin
                     result_reg <= {opdata_a, 32'hFFFF_FFFF};
                  end
               end
            end
            RUN: begin
               if (!cancel) begin
                  rem_reg   <= rem_step;
                  quo_reg   <= quo_step;
                  count_reg <= count_reg + 5'd1;
                  if (count_reg == 5'd31) begin
                     result_reg <= {r_fix, q_fix};
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: table-driven and random divisions checked
// against a queue of expected results, plus cancel/reset/handshake scenarios.
`timescale 1ns/1ps
module tb_div_unit;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic        cancel = 1'b0;
   logic        signed_div = 1'b0;
   logic [31:0] opdata_a = 32'd0;
   logic [31:0] opdata_b = 32'd0;
   logic        busy;
   logic        done;
   logic [63:0] result;

   int total = 0;
   int bad = 0;
   logic [63:0] exp_q[$];

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [63:0] e;
   } vec_t;

   always #5 clk = ~clk;

   div_unit dut (
      .clk(clk),
      .resetn(resetn),
      .start(start),
      .cancel(cancel),
      .signed_div(signed_div),
      .opdata_a(opdata_a),
      .opdata_b(opdata_b),
      .busy(busy),
      .done(done),
      .result(result)
   );

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic [31:0] ma, mb, q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      ma = (s && a[31]) ? (32'd0 - a) : a;
      mb = (s && b[31]) ? (32'd0 - b) : b;
      q = ma / mb;
      r = ma % mb;
      if (s && (a[31] ^ b[31])) q = 32'd0 - q;
      if (s && a[31]) r = 32'd0 - r;
      return {r, q};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one start, waits (bounded) for done, then steps into the first idle cycle.
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] e, output int lat, output logic [63:0] got,
                         output bit busy_drop);
      opdata_a = a;
      opdata_b = b;
      signed_div = s;
      start = 1'b1;
      exp_q.push_back(e);
      tick();
      start = 1'b0;
      lat = -1;
      got = 64'hx;
      busy_drop = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         if (!busy) busy_drop = 1'b1;
         if (done) begin
            lat = n;
            got = result;
            break;
         end
         tick();
      end
      tick();
   endtask

   task automatic test_reset();
      logic [63:0] e;
      resetn = 1'b0;
      tick();
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0) begin
         bad++;
         $display("FAIL reset_hold busy=%b done=%b result=%h want 0/0/0", busy, done, result);
      end
      #2 resetn = 1'b1;
      tick();
      e = 64'd0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== e) begin
         bad++;
         $display("FAIL reset_release busy=%b done=%b result=%h want 0/0/%h", busy, done, result, e);
      end
   endtask

   task automatic test_unsigned_basic();
      int lat;
      logic [63:0] got, e;
      bit drop;
      launch(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, lat, got, drop);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
         bad++;
         $display("FAIL divu_100_7 result=%h want %h", got, e);
      end
      total++;
      if (lat !== 33) begin
         bad++;
         $display("FAIL divu_latency got=%0d want 33", lat);
      end
      total++;
      if (drop !== 1'b0) begin
         bad++;
         $display("FAIL divu_busy_hold busy dropped before done");
      end
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL divu_idle_after busy=%b done=%b want 0/0", busy, done);
      end
   endtask

   task automatic run_table(input string name, input vec_t tbl[3]);
      int lat;
      logic [63:0] got, e;
      bit drop;
      for (int i = 0; i < 3; i++) begin
         launch(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].e, lat, got, drop);
         e = exp_q.pop_front();
         total++;
         if (got !== e || lat !== 33) begin
            bad++;
            $display("FAIL %s[%0d] a=%h b=%h s=%b result=%h lat=%0d want %h lat=33",
                     name, i, tbl[i].a, tbl[i].b, tbl[i].s, got, lat, e);
         end
      end
   endtask

   task automatic test_signed();
      vec_t tbl[3];
      tbl[0] = '{a: 32'hFFFF_FFF9, b: 32'd2,          s: 1'b1, e: {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
      tbl[1] = '{a: 32'd7,          b: 32'hFFFF_FFFE, s: 1'b1, e: {32'h0000_0001, 32'hFFFF_FFFD}};
      tbl[2] = '{a: 32'hFFFF_FFF9, b: 32'hFFFF_FFFE, s: 1'b1, e: {32'hFFFF_FFFF, 32'h0000_0003}};
      run_table("signed", tbl);
   endtask

   task automatic test_extremes();
      vec_t tbl[3];
      tbl[0] = '{a: 32'h8000_0000, b: 32'hFFFF_FFFF, s: 1'b1, e: {32'h0000_0000, 32'h8000_0000}};
      tbl[1] = '{a: 32'h8000_0000, b: 32'hFFFF_FFFF, s: 1'b0, e: {32'h8000_0000, 32'h0000_0000}};
      tbl[2] = '{a: 32'hFFFF_FFFF, b: 32'd1,          s: 1'b0, e: {32'h0000_0000, 32'hFFFF_FFFF}};
      run_table("extreme", tbl);
   endtask

   task automatic test_div_zero();
      int lat;
      logic [63:0] got, e;
      bit drop;
      launch(32'h1234_5678, 32'd0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, lat, got, drop);
      e = exp_q.pop_front();
      total++;
      if (got !== e || lat !== 1) begin
         bad++;
         $display("FAIL div_zero result=%h lat=%0d want %h lat=1", got, lat, e);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL div_zero_busy cycle2 busy=%b want 0", busy);
      end
   endtask

   task automatic test_cancel();
      int lat, dones;
      logic [63:0] got, e;
      bit drop;
      launch(32'hCAFE_F00D, 32'd0, 1'b1, {32'hCAFE_F00D, 32'hFFFF_FFFF}, lat, got, drop);
      e = exp_q.pop_front();
      total++;
      if (got !== e) begin
         bad++;
         $display("FAIL cancel_prior result=%h want %h", got, e);
      end
      opdata_a = 32'd100;
      opdata_b = 32'd7;
      signed_div = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 1; n < 10; n++) tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL cancel_busy cycle11 busy=%b want 0", busy);
      end
      dones = 0;
      for (int n = 0; n < 40; n++) begin
         if (done) dones++;
         tick();
      end
      total++;
      if (dones !== 0 || result !== e) begin
         bad++;
         $display("FAIL cancel_no_done dones=%0d result=%h want 0 and %h", dones, result, e);
      end
   endtask

   task automatic test_reset_mid();
      int dones;
      opdata_a = 32'd100;
      opdata_b = 32'd7;
      signed_div = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 1; n < 10; n++) tick();
      resetn = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0) begin
         bad++;
         $display("FAIL reset_mid busy=%b done=%b result=%h want 0/0/0", busy, done, result);
      end
      tick();
      #2 resetn = 1'b1;
      dones = 0;
      for (int n = 0; n < 40; n++) begin
         tick();
         if (done) dones++;
      end
      total++;
      if (dones !== 0 || busy !== 1'b0 || result !== 64'd0) begin
         bad++;
         $display("FAIL reset_mid_after dones=%0d busy=%b result=%h want 0/0/0", dones, busy, result);
      end
   endtask

   task automatic test_handshake();
      int dones, done_at;
      logic [63:0] e;
      opdata_a = 32'd100;
      opdata_b = 32'd7;
      signed_div = 1'b0;
      start = 1'b1;
      exp_q.push_back({32'd2, 32'd14});
      tick();
      dones = 0;
      done_at = -1;
      for (int n = 1; n <= 70; n++) begin
         if (n == 34) begin
            start = 1'b0;
            total++;
            if (busy !== 1'b0) begin
               bad++;
               $display("FAIL hold_start_idle cycle34 busy=%b want 0", busy);
            end
         end
         if (done) begin
            dones++;
            done_at = n;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
            total++;
            if (result !== e) begin
               bad++;
               $display("FAIL hold_start_result result=%h want %h", result, e);
            end
         end
         tick();
      end
      total++;
      if (dones !== 1 || done_at !== 33) begin
         bad++;
         $display("FAIL hold_start_dones count=%0d at=%0d want 1 at 33", dones, done_at);
      end
      start = 1'b1;
      cancel = 1'b1;
      dones = 0;
      for (int n = 0; n < 4; n++) begin
         tick();
         if (busy || done) dones++;
      end
      start = 1'b0;
      cancel = 1'b0;
      total++;
      if (dones !== 0) begin
         bad++;
         $display("FAIL start_cancel_idle busy/done cycles=%0d want 0", dones);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [63:0] got, e, m;
      bit drop;
      logic [31:0] a, b;
      logic s;
      for (int i = 0; i < 10; i++) begin
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         if (b == 32'd0) b = 32'd3;
         s = 1'($urandom_range(0, 1));
         m = model(a, b, s);
         launch(a, b, s, m, lat, got, drop);
         e = exp_q.pop_front();
         total++;
         if (got !== e || lat !== 33) begin
            bad++;
            $display("FAIL b2b[%0d] a=%h b=%h s=%b result=%h lat=%0d want %h lat=33",
                     i, a, b, s, got, lat, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_basic();
      test_signed();
      test_extremes();
      test_div_zero();
      test_cancel();
      test_reset_mid();
      test_handshake();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 divider for the MIPS DIV/DIVU instructions in the five-stage pipeline. It accepts a dividend/divisor pair from the execute stage, runs one restoring-division step per cycle, and produces a 64-bit {remainder, quotient} result. That result feeds the HI/LO write-data 2:1 select, which picks between divider output and MTHI/MTLO operand. While the unit is busy, the hazard unit stalls the pipeline.

## Interface
Parameters:
- none (fixed 32-bit datapath)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- resetn  input  1  asynchronous, active-low reset
- start  input  1  request a division; sampled only in IDLE
- cancel  input  1  abort the current operation (exception/flush)
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- opdata_a  input  32  dividend; sampled with start
- opdata_b  input  32  divisor; sampled with start
- busy  output  1  high while an operation is in progress (stall request)
- done  output  1  one-cycle pulse: result valid and just updated
- result  output  64  [63:32] remainder (HI), [31:0] quotient (LO); held between operations

## Operation
- Reset: state IDLE; busy=0, done=0, result=64'h0; internal counter and working registers 0.
- States: IDLE, ZERO, RUN, FINISH.
- IDLE: if start=1 and cancel=0, latch the operands and signed_div. Go to ZERO if opdata_b==0, else go to RUN with counter=0.
- Operand conditioning in RUN:
  - Signed mode: divide |a| by |b|, as 32-bit unsigned magnitudes (|0x80000000| = 0x80000000).
  - Unsigned mode: use the operands unchanged.
- RUN: 32 iterations, one per cycle.
  - Each iteration, the 33-bit partial remainder shifts left 1, taking the next dividend MSB.
  - Trial-subtract the divisor. If the result is non-negative, keep it and shift 1 into the quotient; else restore and shift 0.
  - After iteration 32 (counter==31), go to FINISH.
- FINISH:
  - Signed mode: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend (negate if the dividend was negative).
  - Write result, pulse done=1, return to IDLE.
- ZERO: result = {opdata_a, 32'hFFFF_FFFF}; pulse done=1; return to IDLE. The MIPS architecture leaves this undefined; this value is our fixed choice.
- busy=1 in ZERO, RUN and FINISH. The done-pulse cycle is the last busy cycle.
- cancel=1 in any non-IDLE state: next state IDLE, busy=0 next cycle, no done pulse, result unchanged.
- start while busy: ignored, no queueing.
- start and cancel together in IDLE: cancel wins, nothing starts.
- Overflow case (signed 0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. This falls out of the magnitude algorithm; no special handling.
- resetn low at any time, including mid-RUN: immediate return to reset values.

## Timing
- Cycle 0: start sampled in IDLE.
- Cycles 1–32 (busy=1): the 32 RUN iterations.
- Cycle 33: FINISH, busy=1, done=1, result updated on the same edge that raises done.
- Cycle 34: IDLE, busy=0; a new start may be sampled here.
- Normal operation latency: 33 cycles from start to done.
- Divide-by-zero: done in cycle 1; a new start may be sampled in cycle 2.
- Back-to-back: a start asserted in the cycle done is high is ignored.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Unsigned basic: DIVU 100/7 -> done exactly 33 cycles after start, result={32'd2, 32'd14}; busy high cycles 1–33.
- Signed sign rules: DIV -7/2 -> {FFFFFFFF, FFFFFFFD}; DIV 7/-2 -> {00000001, FFFFFFFD}; DIV -7/-2 -> {FFFFFFFF, 00000003}.
- Extremes:
  - DIV 0x80000000/0xFFFFFFFF -> {00000000, 80000000}.
  - DIVU of the same operands -> {80000000, 00000000}.
  - DIVU 0xFFFFFFFF/1 -> {00000000, FFFFFFFF}.
- Divide-by-zero: DIVU 0x12345678/0 -> done in cycle 1, result={12345678, FFFFFFFF}, busy low in cycle 2.
- Cancel and reset: start 100/7, cancel at cycle 10 -> no done, busy=0 from cycle 11, result keeps the prior value. Repeat with resetn pulsed low at cycle 10 -> result=0, busy=0, done=0.
- Handshake: start asserted continuously during an operation -> exactly one done per accepted start; start+cancel together in IDLE -> busy stays 0.
